ro_trng_ctrl: RTL and testbench
===============================

# ro_trng_ctrl

Controller that sequences a bank of ring oscillators into a true-random bit stream. It holds the oscillators halted until started, runs a warm-up period, then samples the XOR of all oscillator outputs through per-bit two-flop synchronizers at a fixed divided rate. It packs samples into words and delivers them over a valid/ready handshake. It sits between the ring-oscillator instances and the consumer of entropy words, and runs a continuous repetition-count health test that latches a failure and shuts the bank down.

## Interface
- NUM_RO, 4: number of ring oscillators sampled; at least 1.
- WARMUP, 64: cycles oscillators run before the first sample; at least 1.
- SAMPLE_DIV, 8: clocks between samples; at least 1.
- WORD, 32: bits per output word; at least 2.
- REP_LIMIT, 16: consecutive identical samples that declare a health failure; 2 ≤ REP_LIMIT.

Ports:
- clock  in  1  single clock for all logic.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  level-sampled request to begin generation.
- stop  in  1  level-sampled request to end generation.
- ro_signal  in  NUM_RO  asynchronous oscillator outputs.
- ro_halt  out  NUM_RO  per-oscillator halt, all bits identical. Drives each oscillator's enable pin: 1 forces the NOR low and stops oscillation.
- data  out  WORD  entropy word.
- valid  out  1  data is available.
- ready  in  1  consumer accepts data.
- busy  out  1  state is not IDLE and not FAIL.
- health_fail  out  1  sticky failure flag.

## Operation
- **Synchronizer:** each ro_signal bit passes through two flops, active in every state. The sample bit s is the XOR-reduction of the second-stage flops.
- **IDLE:** ro_halt all 1.
  - start=1 and stop=0 → WARMUP.
  - start and stop both 1 → stay in IDLE.
- **WARMUP:** ro_halt=0. A counter runs WARMUP cycles, then the FSM goes to COLLECT. stop=1 → IDLE.
- **COLLECT:** ro_halt=0.
  - The divider counts 0..SAMPLE_DIV-1. At count SAMPLE_DIV-1, shreg ← {shreg[WORD-2:0], s}, so the first sample ends in data[WORD-1].
  - After the WORD-th sample → HOLD.
  - stop=1 → IDLE; the partial word is discarded.
- **HOLD:** ro_halt=0, valid=1, and data is stable; no sampling occurs.
  - On valid & ready: if stop is pending → IDLE, else → COLLECT with the divider and bit count cleared.
  - stop asserted in HOLD is latched as pending; the word is still delivered.
- **Health test:**
  - A repetition counter compares each sample with the previous one: equal → counter+1, else counter=1.
  - The counter persists across words and is cleared on entry to WARMUP.
  - When the counter reaches REP_LIMIT → FAIL.
- **FAIL:** health_fail=1, ro_halt all 1, valid=0, busy=0. start is ignored. Only reset_n exits FAIL.
- **Output register:** data updates only on the HOLD entry edge (copy of shreg) and holds otherwise.

## Timing
- Reset values: ro_halt all 1, valid=0, busy=0, health_fail=0, data=0. All counters are 0, the synchronizers are 0, and stop-pending is 0.
- Reset mid-operation: takes effect at the next edge; the partial word is lost and health_fail clears.
- Let the start edge be cycle 0, meaning the FSM enters WARMUP on edge 0:
  - COLLECT is entered on edge WARMUP.
  - Sample k (k=1..WORD) is taken on edge WARMUP + k·SAMPLE_DIV.
  - valid rises on edge WARMUP + WORD·SAMPLE_DIV + 1.
- Sample k reflects ro_signal as registered 2 edges earlier, because of the synchronizer.
- valid falls on the edge after a valid & ready cycle. The next word's first sample is taken SAMPLE_DIV edges after that handshake edge.
- FAIL entry happens on the edge after the REP_LIMIT-th repeated sample. ro_halt rises on that edge.
- Simultaneous events:
  - A failing sample on the WORD-th bit → FAIL; valid never asserts.
  - stop and the handshake in the same HOLD cycle → IDLE.

## Test plan
- **Reset:** hold reset_n=0 for 3 cycles with random inputs → ro_halt=4'hF, valid=0, busy=0, health_fail=0, data=0.
- **Nominal:** NUM_RO=2, WARMUP=4, SAMPLE_DIV=2, WORD=8, REP_LIMIT=6, ready=1. Drive ro_signal so the synchronized XOR at the sample points is 1,0,1,1,0,0,1,0 → valid=1 on edge 21 after start, data=8'hB2, busy=1 throughout.
- **Backpressure:** same parameters, hold ready=0 for 10 cycles after valid → valid and data stay 8'hB2 and no sampling occurs. Then ready=1 for one cycle → valid=0 next edge, and the next sample is taken 2 edges after the handshake.
- **Health failure:** constant ro_signal=0 → health_fail=1 and ro_halt=all 1 one edge after the 6th sample; valid never asserts. Pulsing start → no change. reset_n=0 → health_fail clears.
- **Stop:**
  - stop during COLLECT → IDLE next edge, ro_halt=all 1, valid stays 0.
  - stop during HOLD with ready=0 → valid held until ready=1, then IDLE with busy=0.
  - start and stop together in IDLE → stays IDLE.
- **Reset mid-COLLECT:** after 3 samples, pulse reset_n low → reset values restored. A new start gives a fresh word with valid at edge 21.

Source files
------------

// File: rtl/ro_trng_ctrl.sv
// Ring-oscillator TRNG sequencer: halts the oscillator bank until started,
// warms it up, samples the XOR of the synchronized oscillator outputs at a
// divided rate, packs the samples into words and delivers them over
// valid/ready. A repetition-count health test shuts the bank down on failure.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | oscillators halted, waiting for start
// S_WARM    | oscillators running, warm-up timer counting down
// S_COLLECT | sampling one bit every SAMPLE_DIV clocks into the shift register
// S_HOLD    | word presented on data with valid=1, sampling paused
// S_FAIL    | health test tripped; bank halted until reset_n
module ro_trng_ctrl #(
  parameter int NUM_RO     = 4,
  parameter int WARMUP     = 64,
  parameter int SAMPLE_DIV = 8,
  parameter int WORD       = 32,
  parameter int REP_LIMIT  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [NUM_RO-1:0] ro_signal,
  output logic [NUM_RO-1:0] ro_halt,
  output logic [WORD-1:0]   data,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              health_fail
);

  localparam int WCW = $clog2(WARMUP + 1);
  localparam int DCW = $clog2(SAMPLE_DIV + 1);
  localparam int BCW = $clog2(WORD + 1);
  localparam int RCW = $clog2(REP_LIMIT + 1);

  localparam logic [WCW-1:0] WARM_LOAD = WCW'(WARMUP - 1);
  localparam logic [DCW-1:0] DIV_LAST  = DCW'(SAMPLE_DIV - 1);
  localparam logic [BCW-1:0] WORD_BITS = BCW'(WORD);
  localparam logic [RCW-1:0] REP_MAX   = RCW'(REP_LIMIT);
  localparam logic [DCW-1:0] DIV_ONE   = DCW'(1);
  localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);
  localparam logic [RCW-1:0] REP_ONE   = RCW'(1);
  localparam logic [WCW-1:0] WARM_ONE  = WCW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARM,
    S_COLLECT,
    S_HOLD,
    S_FAIL
  } state_t;

  state_t state, state_nx;

  logic [NUM_RO-1:0] sync1, sync2;
  logic [WCW-1:0]    warm_cnt;
  logic [DCW-1:0]    div_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [RCW-1:0]    rep_cnt;
  logic              prev_s;
  logic [WORD-1:0]   shreg;
  logic              stop_pend;

  logic s;
  logic word_full;
  logic rep_hit;
  logic sample_en;
  logic warm_entry;
  logic hold_entry;

  assign s          = ^sync2;
  assign word_full  = (bit_cnt == WORD_BITS);
  assign rep_hit    = (rep_cnt == REP_MAX);
  assign sample_en  = (state == S_COLLECT) && !rep_hit && !stop && !word_full &&
                      (div_cnt == DIV_LAST);
  assign warm_entry = (state == S_IDLE) && (state_nx == S_WARM);
  assign hold_entry = (state == S_COLLECT) && (state_nx == S_HOLD);

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic; a tripped health test outranks stop and word completion
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start && !stop) state_nx = S_WARM;
      S_WARM: begin
        if (stop)                 state_nx = S_IDLE;
        else if (warm_cnt == '0)  state_nx = S_COLLECT;
      end
      S_COLLECT: begin
        if (rep_hit)              state_nx = S_FAIL;
        else if (stop)            state_nx = S_IDLE;
        else if (word_full)       state_nx = S_HOLD;
      end
      S_HOLD:    if (ready) state_nx = (stop || stop_pend) ? S_IDLE : S_COLLECT;
      S_FAIL:    state_nx = S_FAIL;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Two-flop synchronizer on every oscillator output, running in all states
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ro_signal;
      sync2 <= sync1;
    end
  end

  // Warm-up down-counter, loaded as the bank is released
  always_ff @(posedge clock) begin
    if (!reset_n)                             warm_cnt <= '0;
    else if (warm_entry)                      warm_cnt <= WARM_LOAD;
    else if (state == S_WARM && warm_cnt != '0) warm_cnt <= warm_cnt - WARM_ONE;
  end

  // Sample divider and bit counter; both restart whenever COLLECT is (re)entered
  always_ff @(posedge clock) begin
    if (!reset_n || state != S_COLLECT) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_ONE;
      if (sample_en) bit_cnt <= bit_cnt + BIT_ONE;
    end
  end

  // Shift register, first sample ends up in the MSB
  always_ff @(posedge clock) begin
    if (!reset_n)       shreg <= '0;
    else if (sample_en) shreg <= {shreg[WORD-2:0], s};
  end

  // Repetition-count health test; the run length carries across words
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rep_cnt <= '0;
      prev_s  <= 1'b0;
    end else if (warm_entry) begin
      rep_cnt <= '0;
    end else if (sample_en) begin
      rep_cnt <= (s == prev_s) ? rep_cnt + REP_ONE : REP_ONE;
      prev_s  <= s;
    end
  end

  // Output word register, loaded only as HOLD is entered
  always_ff @(posedge clock) begin
    if (!reset_n)        data <= '0;
    else if (hold_entry) data <= shreg;
  end

  // Stop seen while a word is pending is remembered until the handshake
  always_ff @(posedge clock) begin
    if (!reset_n || state != S_HOLD) stop_pend <= 1'b0;
    else if (ready)                  stop_pend <= 1'b0;
    else if (stop)                   stop_pend <= 1'b1;
  end

  // Status and oscillator control decoded from state
  always_comb begin
    ro_halt     = {NUM_RO{(state == S_IDLE) || (state == S_FAIL)}};
    valid       = (state == S_HOLD);
    busy        = (state != S_IDLE) && (state != S_FAIL);
    health_fail = (state == S_FAIL);
  end

endmodule

// File: tb/tb_ro_trng_ctrl.sv
// Bench for ro_trng_ctrl: drives oscillator patterns so the synchronized XOR
// at each sample point follows a table of words, and checks words through a
// scoreboard plus hand sequences for stop, backpressure, reset and failure.
module tb_ro_trng_ctrl;
  localparam int NUM_RO     = 2;
  localparam int WARMUP     = 4;
  localparam int SAMPLE_DIV = 2;
  localparam int WORD       = 8;
  localparam int REP_LIMIT  = 6;
  localparam int WORD_LAT   = WORD * SAMPLE_DIV + 1;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              ready = 1'b0;
  logic [NUM_RO-1:0] ro_signal = '0;
  logic [NUM_RO-1:0] ro_halt;
  logic [WORD-1:0]   data;
  logic              valid;
  logic              busy;
  logic              health_fail;

  ro_trng_ctrl #(
    .NUM_RO(NUM_RO), .WARMUP(WARMUP), .SAMPLE_DIV(SAMPLE_DIV),
    .WORD(WORD), .REP_LIMIT(REP_LIMIT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
    .ro_signal(ro_signal), .ro_halt(ro_halt), .data(data), .valid(valid),
    .ready(ready), .busy(busy), .health_fail(health_fail)
  );

  always #5 clock = ~clock;

  // samp[0] is the first sample of the word; exp is the word as delivered
  typedef struct {
    logic [7:0] samp;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         win_base = 0;
  logic [7:0] win_samp = '0;
  bit         ro_zero = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive ro_signal for the next edge so the bit for sample k is registered
  // exactly two edges before that sample; all other edges get random values.
  task automatic drive_ro();
    int   off;
    int   idx;
    logic r;
    logic b;
    off = cyc + 1 - win_base;
    r = 1'($urandom_range(0, 1));
    b = 1'($urandom_range(0, 1));
    if (off + 2 >= SAMPLE_DIV && ((off + 2) % SAMPLE_DIV) == 0) begin
      idx = (off + 2) / SAMPLE_DIV;
      if (idx >= 1 && idx <= WORD) b = win_samp[idx-1];
    end
    if (ro_zero) ro_signal = '0;
    else         ro_signal = {r ^ b, r};
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    drive_ro();
  endtask

  task automatic set_window(input int base, input logic [7:0] samp,
                            input bit push, input logic [7:0] exp);
    win_base = base;
    win_samp = samp;
    if (push) exp_q.push_back(exp);
    drive_ro();
  endtask

  task automatic start_run(input logic [7:0] samp, input bit push, input logic [7:0] exp);
    cyc = -1;
    set_window(WARMUP, samp, push, exp);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_cyc);
    int n;
    bit busy_ok;
    n = 0;
    busy_ok = 1'b1;
    while (!valid && n < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      step();
      n++;
    end
    chk({name, "_valid_edge"}, cyc, exp_cyc);
    chk({name, "_busy"}, {31'd0, busy_ok}, 32'd1);
  endtask

  task automatic wait_health(input string name, input int exp_cyc);
    int n;
    n = 0;
    while (!health_fail && n < 200) begin
      step();
      n++;
    end
    chk({name, "_fail_edge"}, cyc, exp_cyc);
  endtask

  // Scoreboard: every accepted word must match the oldest expected word
  always @(negedge clock) begin
    logic [7:0] e;
    if (reset_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h, expected no word", data);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", {24'd0, data}, {24'd0, e});
      end
    end
  end

  initial begin
    bit bp_valid_ok;
    bit bp_data_ok;
    int base;

    vecs[0] = '{samp: 8'h4D, exp: 8'hB2};
    vecs[1] = '{samp: 8'hBE, exp: 8'h7D};
    vecs[2] = '{samp: 8'hC1, exp: 8'h83};
    vecs[3] = '{samp: 8'hAA, exp: 8'h55};
    vecs[4] = '{samp: 8'h0F, exp: 8'hF0};

    // Reset with random inputs
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start     = 1'($urandom_range(0, 1));
      stop      = 1'($urandom_range(0, 1));
      ready     = 1'($urandom_range(0, 1));
      ro_signal = 2'($urandom_range(0, 3));
      @(posedge clock);
      #1;
    end
    chk("rst_halt", ro_halt, 2'b11);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_health", health_fail, 0);
    chk("rst_data", data, 0);
    start = 1'b0; stop = 1'b0; ready = 1'b1; reset_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // Table of words delivered back to back with ready held high
    start_run(vecs[0].samp, 1'b1, vecs[0].exp);
    chk("warm_halt", ro_halt, 2'b00);
    chk("warm_busy", busy, 1);
    wait_valid("word0", WARMUP + WORD_LAT);
    for (int i = 1; i < 5; i++) begin
      base = cyc + 1;
      set_window(base, vecs[i].samp, 1'b1, vecs[i].exp);
      step();
      chk("handshake_valid_low", valid, 0);
      wait_valid($sformatf("word%0d", i), base + WORD_LAT);
    end
    // stop together with the handshake
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_hs_busy", busy, 0);
    chk("stop_hs_valid", valid, 0);
    chk("stop_hs_halt", ro_halt, 2'b11);

    // Backpressure: word held for 10 cycles, next word after the handshake
    ready = 1'b0;
    start_run(vecs[0].samp, 1'b1, vecs[0].exp);
    wait_valid("bp_word", WARMUP + WORD_LAT);
    bp_valid_ok = 1'b1;
    bp_data_ok  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid !== 1'b1) bp_valid_ok = 1'b0;
      if (data !== 8'hB2) bp_data_ok = 1'b0;
    end
    chk("bp_valid_held", {31'd0, bp_valid_ok}, 32'd1);
    chk("bp_data_held", {31'd0, bp_data_ok}, 32'd1);
    ready = 1'b1;
    base = cyc + 1;
    set_window(base, vecs[1].samp, 1'b1, vecs[1].exp);
    step();
    chk("bp_valid_low", valid, 0);
    wait_valid("bp_next", base + WORD_LAT);

    // stop in HOLD with ready low: word still delivered, then IDLE
    ready = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_hold_valid", valid, 1);
    repeat (3) step();
    chk("stop_hold_valid_late", valid, 1);
    chk("stop_hold_busy", busy, 1);
    ready = 1'b1;
    step();
    chk("stop_hold_done_busy", busy, 0);
    chk("stop_hold_done_valid", valid, 0);

    // stop during COLLECT discards the partial word
    start_run(vecs[2].samp, 1'b0, 8'h00);
    repeat (9) step();
    chk("collect_busy", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_collect_busy", busy, 0);
    chk("stop_collect_halt", ro_halt, 2'b11);
    chk("stop_collect_valid", valid, 0);
    repeat (20) step();
    chk("stop_collect_idle", busy, 0);

    // start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    repeat (2) step();
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_busy", busy, 0);
    chk("start_stop_halt", ro_halt, 2'b11);

    // Reset after three samples, then a fresh word
    start_run(vecs[3].samp, 1'b0, 8'h00);
    repeat (10) step();
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    step();
    chk("mid_rst_data", data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_halt", ro_halt, 2'b11);
    chk("mid_rst_valid", valid, 0);
    reset_n = 1'b1;
    step();
    start_run(vecs[0].samp, 1'b1, vecs[0].exp);
    wait_valid("after_rst", WARMUP + WORD_LAT);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("after_rst_idle", busy, 0);

    // Sixth repeat lands on the last bit of the word: FAIL, no valid
    start_run(8'hFD, 1'b0, 8'h00);
    wait_health("last_bit", WARMUP + WORD_LAT);
    chk("last_bit_valid", valid, 0);
    chk("last_bit_data", data, 8'hB2);
    repeat (3) step();
    chk("last_bit_valid_late", valid, 0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("last_bit_rst_health", health_fail, 0);
    step();

    // Constant-zero oscillators fail one edge after the sixth sample
    ro_zero = 1'b1;
    start_run(8'h00, 1'b0, 8'h00);
    wait_health("const0", WARMUP + REP_LIMIT * SAMPLE_DIV + 1);
    chk("const0_halt", ro_halt, 2'b11);
    chk("const0_busy", busy, 0);
    chk("const0_valid", valid, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    chk("fail_start_health", health_fail, 1);
    chk("fail_start_busy", busy, 0);
    chk("fail_start_halt", ro_halt, 2'b11);
    reset_n = 1'b0;
    step();
    chk("fail_rst_health", health_fail, 0);
    reset_n = 1'b1;
    ro_zero = 1'b0;
    step();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
